// File: rtl/fifo_memory_prog_if.sv
// Handshake/status bundle between a FIFO memory driver and the fifo_memory_prog block.
interface fifo_memory_prog_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] din;
  logic                  write;
  logic                  read;
  logic [ADDR_WIDTH:0]   ale_thresh;
  logic [ADDR_WIDTH:0]   alf_thresh;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] dout;
  logic                  empty;
  logic                  full;
  logic                  ale;
  logic                  alf;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output din, write, read, ale_thresh, alf_thresh, err_clr,
    input  dout, empty, full, ale, alf, count, overflow, underflow
  );

  modport slave (
    input  din, write, read, ale_thresh, alf_thresh, err_clr,
    output dout, empty, full, ale, alf, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_memory_prog.sv
// Synchronous FIFO with programmable almost-empty/full thresholds, sticky error flags
// and selectable registered or first-word-fall-through read data.
module fifo_memory_prog #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter bit          FWFT       = 1'b0
) (
  input logic               clk,
  input logic               reset,
  fifo_memory_prog_if.slave bus
);
  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned PtrW  = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [Depth];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]       count;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  empty, full, wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] rd_word;

  // Extra pointer bit makes the difference span 0..Depth without ambiguity.
  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (count == '0);
  assign full    = (count == PtrW'(Depth));
  assign wr_acc  = bus.write & ~full;
  assign rd_acc  = bus.read & ~empty;
  assign rd_word = mem[rd_ptr_q[ADDR_WIDTH-1:0]];

  assign bus.count     = count;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.ale       = (count <= bus.ale_thresh);
  assign bus.alf       = (count >= bus.alf_thresh);
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    // A new error event in the same cycle as err_clr keeps the flag set.
    overflow_d  = (bus.write & full) | (overflow_q & ~bus.err_clr);
    underflow_d = (bus.read & empty) | (underflow_q & ~bus.err_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.din;
  end

  generate
    if (FWFT) begin : g_fwft
      assign bus.dout = empty ? '0 : rd_word;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] dout_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)       dout_q <= '0;
        else if (rd_acc) dout_q <= rd_word;
      end
      assign bus.dout = dout_q;
    end
  endgenerate
endmodule

// File: doc/fifo_memory_prog.md
Name: fifo_memory_prog

Overview:
- Parametrised synchronous FIFO: the next generation of the team's FIFO memory block.
- Adds programmable almost-empty/almost-full thresholds, an occupancy count, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode.
- Single clock domain.
- Sits behind the same driver/monitor-style testbench interface used for FIFO memory blocks.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH entries.
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- din  input  DATA_WIDTH  write data.
- write  input  1  write request.
- read  input  1  read request.
- ale_thresh  input  ADDR_WIDTH+1  almost-empty threshold.
- alf_thresh  input  ADDR_WIDTH+1  almost-full threshold.
- err_clr  input  1  clears the sticky error flags.
- dout  output  DATA_WIDTH  read data.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- ale  output  1  count <= ale_thresh.
- alf  output  1  count >= alf_thresh.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: write attempted while full.
- underflow  output  1  sticky: read attempted while empty.

Behaviour:
- Storage and pointers:
  - Storage is a DEPTH x DATA_WIDTH array; contents are not reset.
  - wr_ptr and rd_ptr are ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits index memory and the MSB distinguishes full from empty.
  - Pointers wrap naturally modulo 2*DEPTH.
- Accept rules, using the registered state at the start of the cycle:
  - wr_acc = write & ~full; rd_acc = read & ~empty.
  - A rejected request has no effect on pointers, count or memory.
- Occupancy update, registered:
  - count += 1 on wr_acc only.
  - count -= 1 on rd_acc only.
  - count is unchanged when both or neither are accepted.
- Flags:
  - empty, full, ale and alf decode combinationally from the registered count and the threshold inputs.
  - They change the cycle after an accepted operation, or immediately when a threshold input changes.
- Simultaneous events:
  - Read and write with 0 < count < DEPTH: both are accepted.
  - Read and write at full: the read is accepted, the write is rejected, overflow is set, and count becomes DEPTH-1.
  - Read and write at empty: the write is accepted, the read is rejected, underflow is set, and count becomes 1.
- Sticky error flags:
  - overflow is set on write & full; underflow is set on read & empty.
  - Both clear on err_clr.
  - If err_clr coincides with a new error event, set wins.
- FWFT=0 (registered read):
  - On rd_acc, dout <= mem[rd_ptr] at that edge: one-cycle latency.
  - Otherwise dout holds its last value.
- FWFT=1 (first-word-fall-through):
  - dout = mem[rd_ptr] combinationally whenever ~empty; dout = 0 when empty.
  - The first written word appears on dout the cycle after its write edge.
  - rd_acc pops the word and presents the next one.
- Reset, asynchronous, effective immediately with no clock required, also when asserted mid-operation:
  - wr_ptr = rd_ptr = 0, count = 0, dout = 0.
  - overflow = underflow = 0.
  - empty = 1, full = 0, ale = 1.
  - alf = (alf_thresh == 0).
  - All queued data is discarded.
- Threshold values outside 0..DEPTH are legal: ale and alf simply follow the compare result.
- No combinational path from read/write to any flag.

Test Plan:
- Fill and overflow (FWFT=0, DEPTH=16):
  - reset, then write 0x00..0x0F on 16 consecutive cycles -> full=1, count=16, alf=1 (alf_thresh=14).
  - 17th write of 0xAA -> overflow=1, count stays 16, 0xAA is never read out.
- Drain and underflow:
  - from full, assert read for 16 cycles -> dout = 0x00..0x0F, each one cycle after its read edge; empty=1 after the 16th read.
  - one extra read -> underflow=1, dout holds 0x0F.
  - err_clr pulse -> both errors 0.
- Thresholds (ale_thresh=2, alf_thresh=14):
  - count 2 -> ale=1; count 3 -> ale=0; count 14 -> alf=1; count 13 -> alf=0.
  - change alf_thresh to 10 at count 12 -> alf=1 with no clock edge.
- Simultaneous and wrap-around:
  - read+write at count=5 for 40 cycles with incrementing data -> count stays 5, output order equals input order across pointer wrap.
  - read+write at full -> count=15, overflow=1.
- FWFT=1:
  - single write of 0x5A into empty FIFO -> dout=0x5A and empty=0 on the next cycle with read low.
  - read -> dout=0, empty=1 the following cycle.
- Reset mid-burst:
  - assert reset between clock edges at count=7 -> count=0, empty=1, dout=0, errors 0 immediately.
  - post-reset write/read of 0x33 returns 0x33.
